// File: rtl/retire_trace_buffer_pkg.sv
// Shared types for the retire trace buffer: event kinds, trace record layout
// and the kind classifier used at capture.
package trace_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned INUM_W = 32;
    localparam int unsigned CYC_W  = 32;
    localparam int unsigned DROP_W = 16;
    localparam int unsigned REG_W  = 5;

    typedef enum logic [2:0] {
        K_NOP = 3'd0,
        K_REG = 3'd1,
        K_LD  = 3'd2,
        K_ST  = 3'd3,
        K_STU = 3'd4
    } trace_kind_e;

    typedef struct packed {
        logic [INUM_W-1:0] inum;
        logic [CYC_W-1:0]  cyc;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   instr;
        trace_kind_e       kind;
        logic [REG_W-1:0]  rd;
        logic [XLEN-1:0]   wdata;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   mdata;
    } trace_rec_t;

    localparam int unsigned REC_W = $bits(trace_rec_t);

    // A register write dominates the classification; a load without a
    // register write carries no architectural effect and is logged as NOP.
    function automatic trace_kind_e classify(input logic reg_write,
                                             input logic mem_read,
                                             input logic mem_write);
        trace_kind_e k;
        k = K_NOP;
        if (reg_write && mem_write)     k = K_STU;
        else if (reg_write && mem_read) k = K_LD;
        else if (reg_write)             k = K_REG;
        else if (mem_write)             k = K_ST;
        return k;
    endfunction

endpackage

// File: rtl/retire_trace_buffer_if.sv
// Retire-side capture bus plus the ready/valid trace drain and status.
interface retire_trace_buffer_if #(
    parameter int unsigned DEPTH = 16
);
    import trace_pkg::*;

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic              en;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   instr;
    logic              reg_write;
    logic [REG_W-1:0]  rd;
    logic [XLEN-1:0]   wdata;
    logic              mem_read;
    logic              mem_write;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_data;
    logic              clr;
    logic              out_valid;
    logic              out_ready;
    trace_rec_t        out_rec;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;
    logic [LVL_W-1:0]  level;

    modport master (
        output en, pc, instr, reg_write, rd, wdata, mem_read, mem_write,
               mem_addr, mem_data, clr, out_ready,
        input  out_valid, out_rec, overflow, drop_count, level
    );

    modport slave (
        input  en, pc, instr, reg_write, rd, wdata, mem_read, mem_write,
               mem_addr, mem_data, clr, out_ready,
        output out_valid, out_rec, overflow, drop_count, level
    );

endinterface

// File: rtl/retire_trace_buffer_fifo.sv
// Synchronous FIFO with flush; head data is read combinationally from storage
// and forced to zero while empty so no stale record is ever presented.
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q,  count_d;
    logic             do_push_c;
    logic             do_pop_c;

    assign empty     = (count_q == '0);
    assign full      = (count_q == LW'(DEPTH));
    assign level     = count_q;
    assign do_pop_c  = pop & ~empty & ~flush;
    // When full, a same-cycle pop frees the slot the push writes into.
    assign do_push_c = push & (~full | do_pop_c) & ~flush;
    assign rdata     = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push_c, do_pop_c})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only observed through a non-empty head.
    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire trace capture: classifies each retiring instruction, stamps it with
// instruction/cycle numbers and queues it; overflow drops and counts, never stalls.
module retire_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    retire_trace_buffer_if.slave bus
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [INUM_W-1:0] inum_q, inum_d;
    logic [CYC_W-1:0]  cyc_q,  cyc_d;
    logic              ovf_q,  ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              capture_c;
    logic              pop_c;
    logic              push_c;
    logic              drop_c;
    trace_kind_e       kind_c;
    trace_rec_t        rec_c;

    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    logic [REC_W-1:0]  fifo_rdata;

    assign capture_c = bus.en & ~bus.clr;
    assign pop_c     = ~fifo_empty & bus.out_ready & ~bus.clr;
    assign push_c    = capture_c & (~fifo_full | pop_c);
    assign drop_c    = capture_c & fifo_full & ~pop_c;

    // Record assembly; fields irrelevant to the kind stay zero.
    always_comb begin
        rec_c       = '0;
        kind_c      = classify(bus.reg_write, bus.mem_read, bus.mem_write);
        rec_c.inum  = inum_q;
        rec_c.cyc   = cyc_q;
        rec_c.pc    = bus.pc;
        rec_c.instr = bus.instr;
        rec_c.kind  = kind_c;
        if (kind_c == K_REG || kind_c == K_LD || kind_c == K_STU) begin
            rec_c.rd    = bus.rd;
            rec_c.wdata = bus.wdata;
        end
        if (kind_c == K_LD || kind_c == K_ST || kind_c == K_STU) begin
            rec_c.addr = bus.mem_addr;
        end
        if (kind_c == K_ST || kind_c == K_STU) begin
            rec_c.mdata = bus.mem_data;
        end
    end

    // inum advances on every capture, stored or dropped, exposing gaps downstream.
    always_comb begin
        cyc_d  = cyc_q + CYC_W'(1);
        inum_d = inum_q;
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (capture_c) inum_d = inum_q + INUM_W'(1);
        if (drop_c) begin
            ovf_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
        end
        if (bus.clr) begin
            cyc_d  = '0;
            inum_d = '0;
            ovf_d  = 1'b0;
            drop_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inum_q <= '0;
            cyc_q  <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            inum_q <= inum_d;
            cyc_q  <= cyc_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.clr),
        .push  (push_c),
        .wdata (rec_c),
        .pop   (pop_c),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign bus.out_valid  = ~fifo_empty;
    assign bus.out_rec    = trace_rec_t'(fifo_rdata);
    assign bus.overflow   = ovf_q;
    assign bus.drop_count = drop_q;
    assign bus.level      = fifo_level;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed and randomized checks of retire_trace_buffer against a queue-based model.
module tb_retire_trace_buffer;
    import trace_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned RW    = $bits(trace_rec_t);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    retire_trace_buffer_if #(.DEPTH(DEPTH)) bus ();

    retire_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    trace_rec_t  mq[$];
    logic [31:0] m_inum;
    logic [31:0] m_cyc;
    logic        m_ovf;
    logic [15:0] m_drop;

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic trace_rec_t model_rec();
        trace_rec_t r;
        r       = '0;
        r.inum  = m_inum;
        r.cyc   = m_cyc;
        r.pc    = bus.pc;
        r.instr = bus.instr;
        if (bus.reg_write && bus.mem_write)     r.kind = K_STU;
        else if (bus.reg_write && bus.mem_read) r.kind = K_LD;
        else if (bus.reg_write)                 r.kind = K_REG;
        else if (bus.mem_write)                 r.kind = K_ST;
        else                                    r.kind = K_NOP;
        if (bus.reg_write) begin
            r.rd    = bus.rd;
            r.wdata = bus.wdata;
        end
        if (bus.mem_write || (bus.reg_write && bus.mem_read)) r.addr = bus.mem_addr;
        if (bus.mem_write) r.mdata = bus.mem_data;
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_inum = '0;
        m_cyc  = '0;
        m_ovf  = 1'b0;
        m_drop = '0;
    endtask

    task automatic check_outputs(input string tag);
        trace_rec_t head;
        head = (mq.size() != 0) ? mq[0] : '0;
        chk({tag, ".out_valid"},  RW'(bus.out_valid),  RW'(mq.size() != 0));
        chk({tag, ".level"},      RW'(bus.level),      RW'(mq.size()));
        chk({tag, ".overflow"},   RW'(bus.overflow),   RW'(m_ovf));
        chk({tag, ".drop_count"}, RW'(bus.drop_count), RW'(m_drop));
        chk({tag, ".out_rec"},    RW'(bus.out_rec),    RW'(head));
    endtask

    // Entered at a negedge with inputs already set; leaves at the next negedge.
    task automatic step(input string tag);
        bit pop;
        check_outputs(tag);
        pop = !bus.clr && bus.out_ready && (mq.size() != 0);
        if (bus.clr) begin
            model_reset();
        end else begin
            if (pop) void'(mq.pop_front());
            if (bus.en) begin
                if (mq.size() < DEPTH) mq.push_back(model_rec());
                else begin
                    m_ovf = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end
                m_inum = m_inum + 32'd1;
            end
            m_cyc = m_cyc + 32'd1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit e, input bit rw, input bit mr, input bit mw,
                         input logic [4:0] rd, input logic [31:0] wd,
                         input logic [31:0] ad, input logic [31:0] md,
                         input logic [31:0] pc);
        bus.en        = e;
        bus.reg_write = rw;
        bus.mem_read  = mr;
        bus.mem_write = mw;
        bus.rd        = rd;
        bus.wdata     = wd;
        bus.mem_addr  = ad;
        bus.mem_data  = md;
        bus.pc        = pc;
        bus.instr     = $urandom;
    endtask

    task automatic drive_rand(input bit e);
        drive(e, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
              $urandom, $urandom, $urandom, $urandom);
    endtask

    initial begin
        model_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
        bus.clr       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        // Single register write, visible one cycle later.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h2A, 32'h1234, 32'h5678, 32'h100);
        bus.out_ready = 1'b1;
        step("reg_cap");
        chk("reg.valid", RW'(bus.out_valid),     RW'(1'b1));
        chk("reg.kind",  RW'(bus.out_rec.kind),  RW'(K_REG));
        chk("reg.inum",  RW'(bus.out_rec.inum),  RW'(32'd0));
        chk("reg.rd",    RW'(bus.out_rec.rd),    RW'(5'd5));
        chk("reg.wdata", RW'(bus.out_rec.wdata), RW'(32'h2A));
        chk("reg.addr",  RW'(bus.out_rec.addr),  RW'(32'd0));
        chk("reg.pc",    RW'(bus.out_rec.pc),    RW'(32'h100));

        // Clear, then ST, LD, STU, NOP streamed through with ready held high.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 32'h1, '0, '0, 32'h0);
        bus.clr = 1'b1;
        step("clr_a");
        bus.clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            trace_kind_e ek;
            case (i)
                0: begin drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h7, 32'h40, 32'hDEAD, 32'h200); ek = K_ST;  end
                1: begin drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'h8, 32'h44, 32'h9,    32'h204); ek = K_LD;  end
                2: begin drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 32'hA, 32'h48, 32'hB,    32'h208); ek = K_STU; end
                default: begin drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'hC, 32'h4C, 32'hD, 32'h20C); ek = K_NOP; end
            endcase
            step("seq");
            chk("seq.kind", RW'(bus.out_rec.kind), RW'(ek));
            chk("seq.inum", RW'(bus.out_rec.inum), RW'(i));
            chk("seq.cyc",  RW'(bus.out_rec.cyc),  RW'(i));
            if (i == 0) begin
                chk("st.addr",  RW'(bus.out_rec.addr),  RW'(32'h40));
                chk("st.mdata", RW'(bus.out_rec.mdata), RW'(32'hDEAD));
                chk("st.wdata", RW'(bus.out_rec.wdata), RW'(32'h0));
            end
        end

        // Overflow: 20 captures into a stalled 16-deep queue.
        bus.clr = 1'b1;
        step("clr_b");
        bus.clr = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_rand(1'b1);
            step("fill");
        end
        chk("ovf.level", RW'(bus.level),      RW'(16));
        chk("ovf.flag",  RW'(bus.overflow),   RW'(1'b1));
        chk("ovf.drops", RW'(bus.drop_count), RW'(4));
        bus.out_ready = 1'b1;
        drive_rand(1'b0);
        for (int i = 0; i < 16; i++) begin
            chk("drain.inum", RW'(bus.out_rec.inum), RW'(i));
            step("drain");
        end
        drive_rand(1'b1);
        step("after_drain");
        chk("gap.inum", RW'(bus.out_rec.inum), RW'(20));

        // Full queue with simultaneous push and pop.
        bus.clr = 1'b1;
        step("clr_c");
        bus.clr = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_rand(1'b1);
            step("fill16");
        end
        bus.out_ready = 1'b1;
        drive_rand(1'b1);
        step("full_pp");
        chk("fullpp.level", RW'(bus.level),      RW'(16));
        chk("fullpp.drops", RW'(bus.drop_count), RW'(0));

        // Leave 5 queued with overflow set, then clear with a same-cycle capture.
        bus.out_ready = 1'b0;
        drive_rand(1'b1);
        step("drop1");
        bus.out_ready = 1'b1;
        drive_rand(1'b0);
        for (int i = 0; i < 11; i++) step("part_drain");
        bus.out_ready = 1'b0;
        chk("pre_clr.level", RW'(bus.level), RW'(5));
        drive_rand(1'b1);
        bus.clr = 1'b1;
        step("clr_d");
        bus.clr = 1'b0;
        chk("clr.level", RW'(bus.level),     RW'(0));
        chk("clr.valid", RW'(bus.out_valid), RW'(1'b0));
        chk("clr.ovf",   RW'(bus.overflow),  RW'(1'b0));
        drive_rand(1'b1);
        step("post_clr");
        chk("clr.inum", RW'(bus.out_rec.inum), RW'(0));

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive_rand(($urandom % 4) != 0);
            bus.out_ready = 1'($urandom % 3 != 0);
            bus.clr       = ($urandom % 64) == 0;
            step("rand");
        end
        bus.clr = 1'b0;

        // Asynchronous reset in the middle of a drain.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_rand(1'b1);
            step("pre_rst");
        end
        bus.out_ready = 1'b1;
        drive_rand(1'b0);
        step("mid_drain");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.valid", RW'(bus.out_valid), RW'(1'b0));
        chk("arst.level", RW'(bus.level),     RW'(0));
        chk("arst.rec",   RW'(bus.out_rec),   RW'(0));
        @(negedge clk);
        model_reset();
        check_outputs("in_rst");
        rst_n = 1'b1;
        drive_rand(1'b1);
        step("post_rst");
        chk("rst.inum", RW'(bus.out_rec.inum), RW'(0));
        chk("rst.cyc",  RW'(bus.out_rec.cyc),  RW'(0));
        step("post_rst2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
